// File: rtl/tally_uart_tx.sv
// tally_uart_tx: serial read-out of the four candidate tallies.
//
// On an accepted report request (idle, counting mode) the four tallies are
// captured and sent as one 6-byte frame on an 8N1, LSB-first line:
//   HEADER, c1, c2, c3, c4, CHK   with CHK = HEADER ^ c1 ^ c2 ^ c3 ^ c4
// Bytes follow each other with no idle gap. The frame always runs to the end
// once started. Only reset can abandon it.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   HEADER        first byte of every frame
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   mode         in   0 = voting, 1 = counting; requests honoured only when 1
//   report_req   in   report request, sampled every edge while idle
//   cand1..4_vote in  8-bit candidate tallies
//   tx           out  registered serial line, idles high
//   busy         out  high from acceptance to end of last stop bit
//   frame_done   out  one-cycle pulse on the edge that completes a frame
module tally_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       report_req,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned BYTE_W = 3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST_DATA = BIT_W'(8);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(5);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q,  baud_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;
  logic [BYTE_W-1:0]   byte_q,  byte_d;
  logic [3:0][7:0]     snap_q,  snap_d;
  logic                tx_q,    tx_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  logic                baud_end_c;
  logic [7:0]          chk_c;
  logic [7:0]          cur_byte_c;

  // Checksum is always taken from the captured snapshot, never the live inputs.
  assign chk_c = HEADER ^ snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3];

  // Byte currently on the line, selected by byte index.
  always_comb begin
    cur_byte_c = HEADER;
    case (byte_q)
      3'd0:    cur_byte_c = HEADER;
      3'd1:    cur_byte_c = snap_q[0];
      3'd2:    cur_byte_c = snap_q[1];
      3'd3:    cur_byte_c = snap_q[2];
      3'd4:    cur_byte_c = snap_q[3];
      3'd5:    cur_byte_c = chk_c;
      default: cur_byte_c = HEADER;
    endcase
  end

  assign baud_end_c = (baud_q == BAUD_LAST);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. tx_d is the value of the bit that starts on this edge.
  // Bit index: 0 = start, 1..8 = d0..d7, 9 = stop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (report_req && mode) begin
          snap_d[0] = cand1_vote;
          snap_d[1] = cand2_vote;
          snap_d[2] = cand3_vote;
          snap_d[3] = cand4_vote;
          byte_d    = '0;
          bit_d     = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end

      START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = BIT_W'(1);
          tx_d    = cur_byte_c[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          bit_d  = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST_DATA) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Leaving bit index b (carrying d[b-1]) so d[b] starts now.
            tx_d = cur_byte_c[3'(bit_q)];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          bit_d  = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            // Stop bit runs straight into the next start bit.
            byte_d  = byte_q + BYTE_W'(1);
            tx_d    = 1'b0;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tally_uart_tx.sv
// Self-checking bench for tally_uart_tx: a line decoder rebuilds bytes from tx,
// and expected frames come from the frame rules (HEADER, tallies, XOR checksum).
module tb_tally_uart_tx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned FRAME = 60 * CPB;
  localparam logic [7:0]  HDR   = 8'hA5;

  logic       clk;
  logic       reset;
  logic       mode;
  logic       report_req;
  logic [7:0] c1, c2, c3, c4;
  logic       tx;
  logic       busy;
  logic       frame_done;

  tally_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .report_req (report_req),
    .cand1_vote (c1),
    .cand2_vote (c2),
    .cand3_vote (c3),
    .cand4_vote (c4),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: checksum from the frame rule.
  function automatic logic [7:0] model_chk(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    return HDR ^ a ^ b ^ c ^ d;
  endfunction

  // Line monitor: decodes 8N1 at mid-bit, counts pulses and busy cycles.
  logic [7:0] rx_q[$];
  int         done_cyc_q[$];
  int         start_cyc_q[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         busy_cycles = 0;
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  bit         prev_busy = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_active = 0;
      prev_busy  = 0;
    end else begin
      if (frame_done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        check("done_tx_high", 32'(tx), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
      end
      if (busy) busy_cycles++;
      if (busy && !prev_busy) start_cyc_q.push_back(cyc);
      prev_busy = busy;
      if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          int k;
          k = mon_cnt / CPB;
          if (k == 0) begin
            check("start_bit", 32'(tx), 32'd0);
          end else if (k <= 8) begin
            mon_byte[k-1] = tx;
          end else begin
            check("stop_bit", 32'(tx), 32'd1);
            rx_q.push_back(mon_byte);
            mon_active = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] t1, t2, t3, t4;
    logic [7:0] chk;
    bit         disturb;
  } vec_t;

  vec_t vecs[6];

  // Check the 6 bytes starting at rx index base against an expected frame.
  task automatic check_frame(input string name, input int base, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                             input logic [7:0] chk);
    logic [7:0] exp[6];
    exp[0] = HDR; exp[1] = a; exp[2] = b; exp[3] = c; exp[4] = d; exp[5] = chk;
    for (int k = 0; k < 6; k++) begin
      if (base + k < rx_q.size())
        check($sformatf("%s_byte%0d", name, k), 32'(rx_q[base+k]), 32'(exp[k]));
      else
        check($sformatf("%s_byte%0d_missing", name, k), 32'd0, 32'd1);
    end
  endtask

  task automatic wait_done(input string name, input int base_done, input int n, input int budget);
    int t;
    t = 0;
    while (done_cnt - base_done < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt - base_done < n) check({name, "_timeout"}, 32'(done_cnt - base_done), 32'(n));
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic [7:0] chk,
                           input bit disturb);
    int base_rx, base_done, base_busy;
    @(negedge clk);
    c1 = a; c2 = b; c3 = c; c4 = d;
    mode = 1'b1;
    report_req = 1'b1;
    base_rx   = rx_q.size();
    base_done = done_cnt;
    base_busy = busy_cycles;
    @(negedge clk);
    report_req = 1'b0;
    if (disturb) begin
      repeat (2 * 10 * CPB + 60) @(negedge clk);
      c1 = 8'd9; c2 = 8'd9; c3 = 8'd9; c4 = 8'd9;
      report_req = 1'b1;
      repeat (3) @(negedge clk);
      report_req = 1'b0;
    end
    wait_done(name, base_done, 1, FRAME + 100);
    repeat (200) @(negedge clk);
    check({name, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cycles - base_busy), 32'(FRAME));
    check({name, "_nbytes"}, 32'(rx_q.size() - base_rx), 32'd6);
    check_frame(name, base_rx, a, b, c, d, chk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx, base_done, base_busy, t;
    logic [7:0] r1, r2, r3, r4;

    vecs[0] = '{8'd3,    8'd1,    8'd0,    8'd255,  8'h58, 1'b0};
    vecs[1] = '{8'd3,    8'd1,    8'd0,    8'd255,  8'h58, 1'b1};
    vecs[2] = '{8'h00,   8'h00,   8'h00,   8'h00,   8'hA5, 1'b0};
    vecs[3] = '{8'hFF,   8'hFF,   8'hFF,   8'hFF,   8'hA5, 1'b0};
    vecs[4] = '{8'h80,   8'h40,   8'h20,   8'h10,   8'h55, 1'b0};
    vecs[5] = '{8'h12,   8'h34,   8'h56,   8'h78,   8'hAD, 1'b0};

    reset = 1'b1; mode = 1'b0; report_req = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;

    // Reset held, then released with no request.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
    end

    // Table vectors (includes the mid-frame disturbance case).
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].t4,
                vecs[i].chk, vecs[i].disturb);

    // Voting mode: requests are dropped.
    @(negedge clk);
    mode = 1'b0;
    report_req = 1'b1;
    base_rx = rx_q.size();
    base_done = done_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("vote_tx", 32'(tx), 32'd1);
      check("vote_busy", 32'(busy), 32'd0);
      check("vote_done", 32'(frame_done), 32'd0);
    end
    report_req = 1'b0;
    repeat (5) @(negedge clk);
    check("vote_nbytes", 32'(rx_q.size() - base_rx), 32'd0);
    check("vote_ndone", 32'(done_cnt - base_done), 32'd0);

    // Reset during byte 3 abandons the frame asynchronously.
    @(negedge clk);
    c1 = 8'd3; c2 = 8'd1; c3 = 8'd0; c4 = 8'd255;
    mode = 1'b1;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    base_done = done_cnt;
    repeat (3 * 10 * CPB + 60) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - base_done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame("after_rst", 8'd1, 8'd2, 8'd3, 8'd4, 8'hA1, 1'b0);

    // Random tallies against the reference checksum.
    for (int i = 0; i < 6; i++) begin
      r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom); r4 = 8'($urandom);
      run_frame($sformatf("rnd%0d", i), r1, r2, r3, r4, model_chk(r1, r2, r3, r4), 1'b0);
    end

    // Request held high: three back-to-back frames, 1 idle cycle between them.
    @(negedge clk);
    r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom); r4 = 8'($urandom);
    c1 = r1; c2 = r2; c3 = r3; c4 = r4;
    mode = 1'b1;
    base_rx = rx_q.size();
    base_done = done_cnt;
    base_busy = busy_cycles;
    report_req = 1'b1;
    wait_done("b2b_two", base_done, 2, 2 * FRAME + 200);
    t = 0;
    while (!busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    report_req = 1'b0;
    wait_done("b2b_three", base_done, 3, FRAME + 100);
    repeat (200) @(negedge clk);
    check("b2b_done_pulses", 32'(done_cnt - base_done), 32'd3);
    check("b2b_busy_cycles", 32'(busy_cycles - base_busy), 32'(3 * FRAME));
    check("b2b_nbytes", 32'(rx_q.size() - base_rx), 32'd18);
    for (int f = 0; f < 3; f++)
      check_frame($sformatf("b2b_f%0d", f), base_rx + 6 * f, r1, r2, r3, r4,
                  model_chk(r1, r2, r3, r4));
    if (done_cyc_q.size() >= 3 && start_cyc_q.size() >= 3) begin
      for (int f = 0; f < 2; f++)
        check($sformatf("b2b_gap%0d", f),
              32'(start_cyc_q[start_cyc_q.size() - 2 + f] - done_cyc_q[done_cyc_q.size() - 3 + f]),
              32'd1);
    end else begin
      check("b2b_gap_records", 32'(done_cyc_q.size()), 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
